// File: rtl/led_pkg.sv
// led_pkg: mode encodings shared by the LED pattern generator and its channels
package led_pkg;
    localparam int MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_PWM   = 2'd3;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel driving OFF, ON, BLINK or PWM from the shared tick
module led_channel
    import led_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              tick,
    input  logic              wrSel,
    input  logic [MODE_W-1:0] wrMode,
    input  logic [CNT_W-1:0]  wrVal,
    output logic              led
);
    logic [MODE_W-1:0] mode;
    logic [CNT_W-1:0]  val;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    logic              ledNext;
    logic              blinkHit;

    // Next counter and LED; a write restarts the channel and swallows a coinciding tick
    always_comb begin
        blinkHit = tick && (cnt == val);
        cntNext  = wrSel ? '0 :
                   (tick && mode == MODE_BLINK) ? (blinkHit ? '0 : cnt + 1'b1) :
                   (tick && mode == MODE_PWM) ? cnt + 1'b1 : cnt;
        ledNext  = wrSel ? 1'b0 :
                   (mode == MODE_ON) ? 1'b1 :
                   (mode == MODE_BLINK) ? (led ^ blinkHit) :
                   (mode == MODE_PWM) ? (cnt < val) : 1'b0;
    end

    // Channel configuration, counter and LED registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode <= MODE_OFF;
            val  <= '0;
            cnt  <= '0;
            led  <= 1'b0;
        end else begin
            mode <= wrSel ? wrMode : mode;
            val  <= wrSel ? wrVal : val;
            cnt  <= cntNext;
            led  <= ledNext;
        end
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver with a shared prescaler tick and per-channel patterns
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PRESCALE = 12,
    parameter int CNT_W    = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              iWrEn,
    input  logic [CH_W-1:0]   iWrCh,
    input  logic [MODE_W-1:0] iWrMode,
    input  logic [CNT_W-1:0]  iWrVal,
    output logic              oTick,
    output logic [NUM_CH-1:0] oLED
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] preCnt;

    // Prescaler wraps at PRESCALE-1 and emits a one-clock tick on the following clock
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            preCnt <= '0;
            oTick  <= 1'b0;
        end else begin
            preCnt <= (preCnt == PS_LAST) ? '0 : preCnt + 1'b1;
            oTick  <= (preCnt == PS_LAST);
        end
    end

    // One channel per LED; channel numbers beyond NUM_CH match no instance and are ignored
    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        led_channel #(.CNT_W(CNT_W)) uCh (
            .CLK    (CLK),
            .RESET  (RESET),
            .tick   (oTick),
            .wrSel  (iWrEn && (iWrCh == CH_W'(i))),
            .wrMode (iWrMode),
            .wrVal  (iWrVal),
            .led    (oLED[i])
        );
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: randomized and directed checks against a tick-counting reference model
module tb_led_pattern_gen;
    localparam int P  = 4;
    localparam int NC = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       iWrEn = 1'b0;
    logic [1:0] iWrCh = '0;
    logic [1:0] iWrMode = '0;
    logic [7:0] iWrVal = '0;
    logic       oTick;
    logic [3:0] oLED;

    logic       wrEn5 = 1'b0;
    logic [2:0] wrCh5 = '0;
    logic [1:0] wrMode5 = '0;
    logic [7:0] wrVal5 = '0;
    logic       oTick5;
    logic [4:0] oLED5;

    int checks = 0;
    int errors = 0;

    // Model: edges since reset release; per channel mode/val and ticks seen since its last write
    int edgeN;
    int mMode [NC];
    int mVal  [NC];
    int mT    [NC];
    int mTprev[NC];
    bit mJust [NC];

    always #5 CLK = ~CLK;

    led_pattern_gen #(.NUM_CH(NC), .PRESCALE(P), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .iWrEn(iWrEn), .iWrCh(iWrCh), .iWrMode(iWrMode),
        .iWrVal(iWrVal), .oTick(oTick), .oLED(oLED)
    );

    led_pattern_gen #(.NUM_CH(5), .PRESCALE(P), .CNT_W(8)) dut5 (
        .CLK(CLK), .RESET(RESET), .iWrEn(wrEn5), .iWrCh(wrCh5), .iWrMode(wrMode5),
        .iWrVal(wrVal5), .oTick(oTick5), .oLED(oLED5)
    );

    function automatic bit tickIn(int e);
        return (e - 1) >= P && ((e - 1) % P) == 0;
    endfunction

    function automatic bit expTick();
        return edgeN >= P && (edgeN % P) == 0;
    endfunction

    function automatic logic [3:0] expLed();
        logic [3:0] r;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            case (mMode[c])
                1:       r[c] = !mJust[c];
                2:       r[c] = ((mT[c] / (mVal[c] + 1)) % 2) == 1;
                3:       r[c] = !mJust[c] && ((mTprev[c] % 256) < mVal[c]);
                default: r[c] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic modelReset();
        edgeN = 0;
        for (int c = 0; c < NC; c++) begin
            mMode[c] = 0; mVal[c] = 0; mT[c] = 0; mTprev[c] = 0; mJust[c] = 0;
        end
    endtask

    task automatic cyc(input bit en, input int ch, input int mode, input int val);
        bit tk;
        iWrEn = en; iWrCh = ch[1:0]; iWrMode = mode[1:0]; iWrVal = val[7:0];
        @(posedge CLK);
        edgeN++;
        tk = tickIn(edgeN);
        for (int c = 0; c < NC; c++) begin
            if (en && ch == c) begin
                mMode[c] = mode; mVal[c] = val; mT[c] = 0; mTprev[c] = 0; mJust[c] = 1;
            end else begin
                mJust[c] = 0; mTprev[c] = mT[c];
                if (tk) mT[c]++;
            end
        end
        #1;
        iWrEn = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (oLED !== 4'b0000 || oTick !== 1'b0) begin
            errors++; $display("FAIL reset_hold led %b tick %b exp 0000 0", oLED, oTick);
        end
        RESET = 1'b0;
        modelReset();
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 0, 0, 0);
            checks++;
            if (oTick !== (i == P)) begin
                errors++; $display("FAIL first_tick clk %0d got %b exp %b", i, oTick, (i == P));
            end
            checks++;
            if (oLED !== 4'b0000 || oLED5 !== 5'b00000) begin
                errors++; $display("FAIL reset_led clk %0d got %b/%b exp 0", i, oLED, oLED5);
            end
        end
    endtask

    task automatic test_on_off();
        cyc(1, 1, 1, 0);
        checks++;
        if (oLED !== 4'b0000) begin errors++; $display("FAIL on_write_edge got %b exp 0000", oLED); end
        cyc(0, 0, 0, 0);
        checks++;
        if (oLED !== 4'b0010) begin errors++; $display("FAIL on_next got %b exp 0010", oLED); end
        repeat (5) cyc(0, 0, 0, 0);
        checks++;
        if (oLED !== expLed()) begin errors++; $display("FAIL on_hold got %b exp %b", oLED, expLed()); end
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        checks++;
        if (oLED !== 4'b0000) begin errors++; $display("FAIL off got %b exp 0000", oLED); end
    endtask

    task automatic test_blink();
        int lastE;
        logic prev;
        cyc(1, 0, 2, 2);
        checks++;
        if (oLED[0] !== 1'b0) begin errors++; $display("FAIL blink_start got %b exp 0", oLED[0]); end
        lastE = -1;
        prev = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cyc(0, 0, 0, 0);
            checks++;
            if (oLED !== expLed()) begin
                errors++; $display("FAIL blink_model edge %0d got %b exp %b", edgeN, oLED, expLed());
            end
            if (oLED[0] !== prev) begin
                if (lastE >= 0) begin
                    checks++;
                    if (edgeN - lastE != 12) begin
                        errors++; $display("FAIL blink_period got %0d exp 12", edgeN - lastE);
                    end
                end
                lastE = edgeN;
                prev = oLED[0];
            end
        end
    endtask

    task automatic test_pwm();
        int hi;
        cyc(1, 2, 3, 64);
        for (int n = 0; n < 2 * P && !tickIn(edgeN); n++) cyc(0, 0, 0, 0);
        hi = 0;
        for (int i = 0; i < 256 * P; i++) begin
            cyc(0, 0, 0, 0);
            if (oLED[2] === 1'b1) hi++;
            checks++;
            if (oLED !== expLed()) begin
                errors++; $display("FAIL pwm_model edge %0d got %b exp %b", edgeN, oLED, expLed());
            end
        end
        checks++;
        if (hi != 64 * P) begin errors++; $display("FAIL pwm_duty64 got %0d exp %0d", hi, 64 * P); end
        cyc(1, 2, 3, 0);
        hi = 0;
        for (int i = 0; i < 256 * P; i++) begin
            cyc(0, 0, 0, 0);
            if (oLED[2] === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL pwm_duty0 got %0d exp 0", hi); end
        cyc(1, 2, 0, 0);
    endtask

    task automatic test_write_on_tick();
        int n;
        cyc(1, 3, 2, 1);
        repeat (7) cyc(0, 0, 0, 0);
        for (int k = 0; k < 2 * P && !tickIn(edgeN + 1); k++) cyc(0, 0, 0, 0);
        checks++;
        if (!tickIn(edgeN + 1) || oTick !== 1'b1) begin
            errors++; $display("FAIL tick_align oTick %b exp 1", oTick);
        end
        cyc(1, 3, 2, 1);
        checks++;
        if (oLED[3] !== 1'b0) begin errors++; $display("FAIL tick_write_led got %b exp 0", oLED[3]); end
        n = 0;
        while (oLED[3] !== 1'b1 && n < 40) begin
            cyc(0, 0, 0, 0);
            n++;
            checks++;
            if (oLED !== expLed()) begin
                errors++; $display("FAIL tick_write_model edge %0d got %b exp %b", edgeN, oLED, expLed());
            end
        end
        checks++;
        if (n != 2 * P) begin errors++; $display("FAIL tick_write_toggle got %0d clocks exp %0d", n, 2 * P); end
    endtask

    task automatic test_out_of_range();
        for (int c = 5; c < 8; c++) begin
            wrEn5 = 1'b1; wrCh5 = 3'(c); wrMode5 = 2'd1; wrVal5 = 8'd0;
            cyc(0, 0, 0, 0);
            wrEn5 = 1'b0;
            cyc(0, 0, 0, 0);
            checks++;
            if (oLED5 !== 5'b00000) begin errors++; $display("FAIL range_ch%0d got %b exp 00000", c, oLED5); end
        end
        wrEn5 = 1'b1; wrCh5 = 3'd4; wrMode5 = 2'd1;
        cyc(0, 0, 0, 0);
        wrEn5 = 1'b1; wrCh5 = 3'd7; wrMode5 = 2'd0;
        cyc(0, 0, 0, 0);
        wrEn5 = 1'b0;
        cyc(0, 0, 0, 0);
        checks++;
        if (oLED5 !== 5'b10000) begin errors++; $display("FAIL range_ch4 got %b exp 10000", oLED5); end
    endtask

    task automatic test_random();
        bit en;
        int ch, mode, val;
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 7) == 0);
            ch = $urandom_range(0, NC - 1);
            mode = $urandom_range(0, 3);
            val = (mode == 2) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            cyc(en, ch, mode, val);
            checks++;
            if (oLED !== expLed() || oTick !== expTick()) begin
                errors++;
                $display("FAIL random edge %0d led %b tick %b exp %b %b", edgeN, oLED, oTick, expLed(), expTick());
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        cyc(1, 0, 2, 0);
        n = 0;
        while (oLED[0] !== 1'b1 && n < 20) begin cyc(0, 0, 0, 0); n++; end
        checks++;
        if (oLED[0] !== 1'b1) begin errors++; $display("FAIL areset_setup got %b exp 1", oLED[0]); end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (oLED !== 4'b0000 || oTick !== 1'b0) begin
            errors++; $display("FAIL areset_async led %b tick %b exp 0000 0", oLED, oTick);
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        modelReset();
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 0, 0, 0);
            checks++;
            if (oLED !== 4'b0000 || oTick !== (i == P)) begin
                errors++; $display("FAIL areset_after clk %0d led %b tick %b", i, oLED, oTick);
            end
        end
        cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 0);
        checks++;
        if (oLED !== 4'b0010) begin errors++; $display("FAIL areset_resume got %b exp 0010", oLED); end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_on_off();
        test_blink();
        test_pwm();
        test_write_on_tick();
        test_out_of_range();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
